// File: rtl/sdram_cache_pkg.sv
// sdram_cache_pkg -- state encoding and sizing helpers for sdram_cache.
// Build macro SDRAM_CACHE_STATS_EN enables the read hit/miss counters.
package sdram_cache_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    MEM_RD,
    MEM_WR,
    DONE
  } state_e;

  localparam int ENTRIES_DEF = 256;
  localparam int ADDR_W_DEF  = 23;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int addr_w, input int entries);
    return addr_w - $clog2(entries) - 2;
  endfunction

  localparam int IDX_DEF   = idx_w(ENTRIES_DEF);
  localparam int TAG_W_DEF = tag_w(ADDR_W_DEF, ENTRIES_DEF);

endpackage

// File: rtl/sdram_cache_ram.sv
// sdram_cache_ram -- 1R1W line store: data word, tag and valid bit.
// Synchronous read; data has per-byte enables, tag/valid share one enable.
module sdram_cache_ram #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8,
  parameter int TAG_W = 13
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata,
  output logic [TAG_W-1:0] rtag,
  output logic             rvalid,
  input  logic             we,
  input  logic [3:0]       wbe,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [TAG_W-1:0] wtag,
  input  logic             wvalid
);

  logic [31:0]      data_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem   [DEPTH];
  logic             valid_mem [DEPTH];

  logic [31:0]      rdata_q;
  logic [TAG_W-1:0] rtag_q;
  logic             rvalid_q;

  // write port: tag/valid on we, data bytes on wbe
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[waddr]   <= wtag;
      valid_mem[waddr] <= wvalid;
    end
    for (int b = 0; b < 4; b++) begin
      if (wbe[b]) begin
        data_mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // registered read port
  always_ff @(posedge clk) begin
    rdata_q  <= data_mem[raddr];
    rtag_q   <= tag_mem[raddr];
    rvalid_q <= valid_mem[raddr];
  end

  assign rdata  = rdata_q;
  assign rtag   = rtag_q;
  assign rvalid = rvalid_q;

endmodule

// File: rtl/sdram_cache.sv
// sdram_cache -- direct-mapped, write-through, no-write-allocate word cache.
// Build macro SDRAM_CACHE_STATS_EN adds read hit/miss counters.
module sdram_cache
  import sdram_cache_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  input  logic [3:0]        wmask,
  input  logic              valid,
  output logic [31:0]       dout,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic [3:0]        mem_wmask,
  output logic              mem_valid,
  input  logic [31:0]       mem_dout,
  input  logic              mem_ready,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
);

  localparam int IDX = idx_w(ENTRIES);
  localparam int TW  = tag_w(ADDR_W, ENTRIES);
  localparam int WA  = ADDR_W - 2;

  state_e            state_q, state_d;
  logic [IDX-1:0]    init_idx_q, init_idx_d;
  logic [WA-1:0]     req_wa_q, req_wa_d;
  logic [31:0]       req_din_q, req_din_d;
  logic [3:0]        req_wm_q, req_wm_d;
  logic [31:0]       dout_q, dout_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_din_q, mem_din_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic              mem_valid_q, mem_valid_d;

  logic [IDX-1:0]    ram_raddr, ram_waddr;
  logic [31:0]       ram_rdata, ram_wdata;
  logic [TW-1:0]     ram_rtag, ram_wtag;
  logic              ram_rvalid, ram_we, ram_wvalid;
  logic [3:0]        ram_wbe;

  logic [IDX-1:0]    req_idx;
  logic [TW-1:0]     req_tag;
  logic              hit;
  logic              is_read;
  logic              unused_addr_lo;

  assign req_idx        = req_wa_q[IDX-1:0];
  assign req_tag        = req_wa_q[WA-1:IDX];
  assign hit            = ram_rvalid && (ram_rtag == req_tag);
  assign is_read        = (req_wm_q == 4'b0000);
  assign unused_addr_lo = ^addr[1:0];

  sdram_cache_ram #(
    .DEPTH (ENTRIES),
    .IDX_W (IDX),
    .TAG_W (TW)
  ) u_ram (
    .clk    (clk),
    .raddr  (ram_raddr),
    .rdata  (ram_rdata),
    .rtag   (ram_rtag),
    .rvalid (ram_rvalid),
    .we     (ram_we),
    .wbe    (ram_wbe),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .wtag   (ram_wtag),
    .wvalid (ram_wvalid)
  );

  // next-state, line updates and downstream request
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    req_wa_d    = req_wa_q;
    req_din_d   = req_din_q;
    req_wm_d    = req_wm_q;
    dout_d      = dout_q;
    ready_d     = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_wmask_d = mem_wmask_q;
    mem_valid_d = mem_valid_q;
    ram_raddr   = req_idx;
    ram_waddr   = req_idx;
    ram_we      = 1'b0;
    ram_wbe     = 4'b0000;
    ram_wdata   = req_din_q;
    ram_wtag    = req_tag;
    ram_wvalid  = 1'b1;
    unique case (state_q)
      INIT: begin
        ram_we     = 1'b1;
        ram_wvalid = 1'b0;
        ram_waddr  = init_idx_q;
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == IDX'(ENTRIES - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        ram_raddr = addr[IDX+1:2];
        if (valid && !ready_q) begin
          req_wa_d  = addr[ADDR_W-1:2];
          req_din_d = din;
          req_wm_d  = wmask;
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        mem_addr_d = {req_wa_q, 2'b00};
        if (is_read) begin
          if (hit) begin
            dout_d  = ram_rdata;
            ready_d = 1'b1;
            state_d = DONE;
          end else begin
            mem_valid_d = 1'b1;
            mem_wmask_d = 4'b0000;
            state_d     = MEM_RD;
          end
        end else begin
          if (hit) begin
            ram_wbe = req_wm_q;
          end
          mem_valid_d = 1'b1;
          mem_din_d   = req_din_q;
          mem_wmask_d = req_wm_q;
          state_d     = MEM_WR;
        end
      end
      MEM_RD: begin
        if (mem_ready) begin
          ram_we      = 1'b1;
          ram_wbe     = 4'b1111;
          ram_wdata   = mem_dout;
          dout_d      = mem_dout;
          ready_d     = 1'b1;
          mem_valid_d = 1'b0;
          state_d     = DONE;
        end
      end
      MEM_WR: begin
        if (mem_ready) begin
          ready_d     = 1'b1;
          mem_valid_d = 1'b0;
          mem_wmask_d = 4'b0000;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // state, request latch and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= INIT;
      init_idx_q  <= '0;
      req_wa_q    <= '0;
      req_din_q   <= '0;
      req_wm_q    <= '0;
      dout_q      <= '0;
      ready_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_wmask_q <= '0;
      mem_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      req_wa_q    <= req_wa_d;
      req_din_q   <= req_din_d;
      req_wm_q    <= req_wm_d;
      dout_q      <= dout_d;
      ready_q     <= ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_wmask_q <= mem_wmask_d;
      mem_valid_q <= mem_valid_d;
    end
  end

  assign dout      = dout_q;
  assign ready     = ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_valid = mem_valid_q;

`ifdef SDRAM_CACHE_STATS_EN
  logic [31:0] hits_q, hits_d;
  logic [31:0] misses_q, misses_d;

  // count each read lookup as a hit or a miss
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (state_q == LOOKUP && is_read) begin
      if (hit) begin
        hits_d = hits_q + 32'd1;
      end else begin
        misses_d = misses_q + 32'd1;
      end
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = 32'd0;
  assign stat_misses = 32'd0;
`endif

endmodule

// File: tb/tb_sdram_cache.sv
// tb_sdram_cache -- randomized bench with a transparent-cache reference model.
// Honours SDRAM_CACHE_STATS_EN when checking the counters.
module tb_sdram_cache;

  logic        clk = 1'b0;
  logic        resetn;
  logic [22:0] addr;
  logic [31:0] din;
  logic [3:0]  wmask;
  logic        valid;
  logic [31:0] dout;
  logic        ready;
  logic [22:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_wmask;
  logic        mem_valid;
  logic [31:0] mem_dout;
  logic        mem_ready;
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;

  always #5 clk = ~clk;

  sdram_cache dut (
    .clk         (clk),
    .resetn      (resetn),
    .addr        (addr),
    .din         (din),
    .wmask       (wmask),
    .valid       (valid),
    .dout        (dout),
    .ready       (ready),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_wmask   (mem_wmask),
    .mem_valid   (mem_valid),
    .mem_dout    (mem_dout),
    .mem_ready   (mem_ready),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
  );

  int total = 0;
  int bad   = 0;

  // model: SDRAM contents by word, and which word each index last filled
  logic [31:0] sdram [int];
  int          cached [int];
  int          hits_m;
  int          misses_m;

  function automatic logic [31:0] sd_rd(input int w);
    if (!sdram.exists(w)) sdram[w] = $urandom;
    return sdram[w];
  endfunction

  task automatic access(input logic [22:0] a, input logic [31:0] d,
                        input logic [3:0] m, output logic [31:0] rd,
                        output int lat, output int nreq);
    int          wait_n;
    bit          pend;
    bit          got;
    logic [22:0] exp_ma;
    exp_ma = {a[22:2], 2'b00};
    addr = a; din = d; wmask = m; valid = 1'b1;
    lat = 0; nreq = 0; pend = 0; got = 0; rd = '0; wait_n = 0;
    while (!got && lat < 600) begin
      @(negedge clk);
      lat++;
      if (mem_ready) begin
        mem_ready = 1'b0;
        total++;
        if (mem_valid !== 1'b0) begin
          bad++;
          $display("FAIL stale_mem_valid got=%b want=0", mem_valid);
        end
      end
      if (ready) begin
        rd  = dout;
        got = 1;
      end else if (mem_valid) begin
        if (!pend) begin
          pend = 1;
          nreq++;
          wait_n = $urandom_range(0, 3);
          total++;
          if (mem_addr !== exp_ma || mem_wmask !== m) begin
            bad++;
            $display("FAIL mem_req addr=%h/%h mask=%b/%b (got/want)",
                     mem_addr, exp_ma, mem_wmask, m);
          end
          if (m != 4'b0000) begin
            total++;
            if (mem_din !== d) begin
              bad++;
              $display("FAIL mem_din got=%h want=%h", mem_din, d);
            end
          end
        end
        if (wait_n == 0) begin
          mem_ready = 1'b1;
          mem_dout  = sd_rd(int'(a[22:2]));
          pend      = 0;
        end else begin
          wait_n--;
        end
      end
    end
    valid = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL access_timeout addr=%h got=no_ready want=ready", a);
    end
    @(negedge clk);
  endtask

  task automatic do_op(input logic [22:0] a, input logic [31:0] d,
                       input logic [3:0] m, input string nm,
                       output logic [31:0] rd, output int nreq);
    int          w;
    int          ix;
    int          lat;
    int          exp_req;
    bit          hit;
    logic [31:0] exp_rd;
    logic [31:0] old;
    w   = int'(a[22:2]);
    ix  = w % 256;
    hit = cached.exists(ix) && cached[ix] == w;
    exp_req = (m == 4'b0000 && hit) ? 0 : 1;
    access(a, d, m, rd, lat, nreq);
    total++;
    if (nreq !== exp_req) begin
      bad++;
      $display("FAIL %s nreq got=%0d want=%0d", nm, nreq, exp_req);
    end
    if (m == 4'b0000) begin
      exp_rd = sd_rd(w);
      total++;
      if (rd !== exp_rd) begin
        bad++;
        $display("FAIL %s rdata got=%h want=%h", nm, rd, exp_rd);
      end
      if (hit) begin
        hits_m++;
        total++;
        if (lat != 2) begin
          bad++;
          $display("FAIL %s hit_latency got=%0d want=2", nm, lat);
        end
      end else begin
        misses_m++;
        cached[ix] = w;
      end
    end else begin
      old = sd_rd(w);
      for (int b = 0; b < 4; b++) begin
        if (m[b]) old[8*b +: 8] = d[8*b +: 8];
      end
      sdram[w] = old;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; valid = 1'b0; addr = '0; din = '0; wmask = '0;
    mem_ready = 1'b0; mem_dout = '0;
    repeat (3) @(negedge clk);
    total++;
    if (ready !== 1'b0 || mem_valid !== 1'b0 || dout !== 32'd0) begin
      bad++;
      $display("FAIL reset_out ready=%b mv=%b dout=%h want 0", ready, mem_valid, dout);
    end
    total++;
    if (mem_addr !== 23'd0 || mem_din !== 32'd0 || mem_wmask !== 4'd0) begin
      bad++;
      $display("FAIL reset_mem ma=%h md=%h mw=%b want 0", mem_addr, mem_din, mem_wmask);
    end
    total++;
    if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin
      bad++;
      $display("FAIL reset_stats h=%0d m=%0d want 0", stat_hits, stat_misses);
    end
  endtask

  task automatic test_init_miss();
    int first_mv;
    bit rdy_seen;
    first_mv = 0; rdy_seen = 0;
    resetn = 1'b1; valid = 1'b1; addr = 23'h000100; wmask = 4'b0000;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (ready) rdy_seen = 1;
      if (mem_valid) begin
        first_mv = k;
        break;
      end
    end
    total++;
    if (rdy_seen || first_mv != 258) begin
      bad++;
      $display("FAIL init_len first_mem_valid=%0d want=258 ready_seen=%0d", first_mv, rdy_seen);
    end
    total++;
    if (mem_addr !== 23'h000100 || mem_wmask !== 4'b0000) begin
      bad++;
      $display("FAIL first_miss_req ma=%h mw=%b want 000100/0000", mem_addr, mem_wmask);
    end
    mem_ready = 1'b1; mem_dout = 32'hAABBCCDD;
    @(negedge clk);
    mem_ready = 1'b0;
    total++;
    if (ready !== 1'b1 || dout !== 32'hAABBCCDD || mem_valid !== 1'b0) begin
      bad++;
      $display("FAIL first_fill ready=%b dout=%h mv=%b want 1/aabbccdd/0", ready, dout, mem_valid);
    end
    valid = 1'b0;
    @(negedge clk);
    sdram[32'h40] = 32'hAABBCCDD;
    cached[32'h40] = 32'h40;
    misses_m++;
  endtask

  task automatic test_hit_repeat();
    logic [31:0] rd;
    int n;
    do_op(23'h000100, 32'd0, 4'b0000, "hit_repeat", rd, n);
    total++;
    if (rd !== 32'hAABBCCDD || n != 0) begin
      bad++;
      $display("FAIL hit_repeat rd=%h nreq=%0d want aabbccdd/0", rd, n);
    end
  endtask

  task automatic test_write_merge();
    logic [31:0] rd;
    int n;
    do_op(23'h000100, 32'h12345678, 4'b0011, "write_merge_wr", rd, n);
    do_op(23'h000100, 32'd0, 4'b0000, "write_merge_rd", rd, n);
    total++;
    if (rd !== 32'hAABB5678 || n != 0) begin
      bad++;
      $display("FAIL write_merge rd=%h nreq=%0d want aabb5678/0", rd, n);
    end
  endtask

  task automatic test_back_to_back();
    bit extra;
    extra = 0;
    valid = 1'b1; addr = 23'h000100; wmask = 4'b0000;
    repeat (2) @(negedge clk);
    total++;
    if (ready !== 1'b1 || dout !== 32'hAABB5678) begin
      bad++;
      $display("FAIL b2b_hit ready=%b dout=%h want 1/aabb5678", ready, dout);
    end
    hits_m++;
    mem_ready = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (ready || mem_valid) extra = 1;
    end
    total++;
    if (extra) begin
      bad++;
      $display("FAIL no_reaccept got=activity want=idle");
    end
  endtask

  task automatic test_conflict();
    logic [31:0] rd;
    int n0, n1, n2;
    do_op(23'h000000, 32'd0, 4'b0000, "conflict_a", rd, n0);
    do_op(23'h000400, 32'd0, 4'b0000, "conflict_b", rd, n1);
    do_op(23'h000000, 32'd0, 4'b0000, "conflict_c", rd, n2);
    total++;
    if (n0 + n1 + n2 != 3) begin
      bad++;
      $display("FAIL conflict downstream_reads got=%0d want=3", n0 + n1 + n2);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [22:0] a;
    logic [3:0]  m;
    int          n;
    int          t;
    int          ix;
    for (int i = 0; i < 150; i++) begin
      t  = $urandom_range(0, 3);
      if (t == 3) t = 13'h1FFF;
      ix = $urandom_range(0, 7);
      a  = 23'((t * 256 + ix) * 4 + $urandom_range(0, 3));
      m  = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      do_op(a, $urandom, m, "random", rd, n);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int n;
    bit seen;
    seen = 0;
    valid = 1'b1; addr = 23'h7FFFF0; wmask = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_valid) begin
        seen = 1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL mid_req got=no_mem_valid want=mem_valid");
    end
    resetn = 1'b0; valid = 1'b0;
    @(negedge clk);
    total++;
    if (mem_valid !== 1'b0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset mv=%b ready=%b want 0/0", mem_valid, ready);
    end
    resetn = 1'b1; mem_ready = 1'b1; mem_dout = 32'hDEADBEEF;
    @(negedge clk);
    mem_ready = 1'b0;
    total++;
    if (mem_valid !== 1'b0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL late_mem_ready mv=%b ready=%b want 0/0", mem_valid, ready);
    end
    cached.delete();
    hits_m = 0;
    misses_m = 0;
    do_op(23'h000100, 32'd0, 4'b0000, "post_reset_miss", rd, n);
    do_op(23'h000100, 32'd0, 4'b0000, "post_reset_hit", rd, n);
  endtask

  task automatic test_stats();
    int eh, em;
`ifdef SDRAM_CACHE_STATS_EN
    eh = hits_m;
    em = misses_m;
`else
    eh = 0;
    em = 0;
`endif
    total++;
    if (stat_hits !== 32'(eh) || stat_misses !== 32'(em)) begin
      bad++;
      $display("FAIL stats hits=%0d/%0d misses=%0d/%0d (got/want)",
               stat_hits, eh, stat_misses, em);
    end
  endtask

  initial begin
    hits_m = 0;
    misses_m = 0;
    test_reset();
    test_init_miss();
    test_hit_repeat();
    test_write_merge();
    test_back_to_back();
    test_conflict();
    test_random();
    test_reset_mid();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
